mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 26 ++
 rtl/mem_stage_if.sv | 29 ++
 rtl/mem_stage_data_ram.sv | 45 ++++
 rtl/mem_stage.sv | 122 ++++++++++++
 tb/tb_mem_stage.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared ARM pipeline definitions for the memory stage: FSM encoding,
// default geometry and the latched-request record.
package mem_stage_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } mem_state_t;

   localparam int WAIT_CYCLES_DEF = 2;
   localparam int MEM_BYTES_DEF   = 256;

   typedef struct packed {
      logic [31:0] data;
      logic        load;
      logic        byte_acc;
      logic [3:0]  rd;
   } mem_req_t;

   // Byte accesses never fault; word accesses need addr[1:0] == 0.
   function automatic logic is_aligned(input logic [1:0] addr_lo, input logic byte_acc);
      return byte_acc || (addr_lo == 2'b00);
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Pipeline-side bus of the memory stage: EX-stage request in, stall and
// write-back results out.
interface mem_stage_if;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic        mem_en;
   logic        load_instr;
   logic        byte_acc;
   logic [31:0] alu_result;
   logic        rf_we_in;
   logic [3:0]  rd_in;
   logic        stall;
   logic [31:0] wb_data;
   logic [3:0]  wb_rd;
   logic        wb_we;
   logic        align_fault;

   modport master (
      output addr, store_data, mem_en, load_instr, byte_acc,
             alu_result, rf_we_in, rd_in,
      input  stall, wb_data, wb_rd, wb_we, align_fault
   );

   modport slave (
      input  addr, store_data, mem_en, load_instr, byte_acc,
             alu_result, rf_we_in, rd_in,
      output stall, wb_data, wb_rd, wb_we, align_fault
   );
endinterface

// File: rtl/mem_stage_data_ram.sv
// Byte-addressable big-endian data storage: combinational read, synchronous
// write, byte or word lanes. Contents are never reset.
module data_ram #(
   parameter int MEM_BYTES = 256,
   parameter int AW        = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic          byte_sel,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [7:0]    mem [MEM_BYTES];
   logic [AW-1:0] addr_b1;
   logic [AW-1:0] addr_b2;
   logic [AW-1:0] addr_b3;

   // Index arithmetic is AW bits wide, so it wraps modulo MEM_BYTES.
   assign addr_b1 = addr + AW'(1);
   assign addr_b2 = addr + AW'(2);
   assign addr_b3 = addr + AW'(3);

   always_ff @(posedge clk) begin
      if (we) begin
         if (byte_sel) begin
            mem[addr] <= wdata[7:0];
         end else begin
            mem[addr]    <= wdata[31:24];
            mem[addr_b1] <= wdata[23:16];
            mem[addr_b2] <= wdata[15:8];
            mem[addr_b3] <= wdata[7:0];
         end
      end
   end

   always_comb begin
      rdata = {24'd0, mem[addr]};
      if (!byte_sel) begin
         rdata = {mem[addr], mem[addr_b1], mem[addr_b2], mem[addr_b3]};
      end
   end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: multi-cycle load/store with wait states, ALU
// pass-through for non-memory instructions, and misaligned-word detection.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int MEM_BYTES   = MEM_BYTES_DEF,
   parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset_n,
   mem_stage_if.slave  bus
);

   localparam int AW    = $clog2(MEM_BYTES);
   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   mem_state_t     state_q;
   logic [CNT_W-1:0] cnt_q;

   mem_req_t       req_p0;
   logic [AW-1:0]  req_addr_p0;

   logic [31:0]    wb_data_p1;
   logic [3:0]     wb_rd_p1;
   logic           wb_we_p1;
   logic           fault_p1;

   logic           req_ok;
   logic           accept;
   logic           access_now;
   logic           ram_we;
   logic [31:0]    ram_rdata;
   logic           unused_addr_hi;

   assign unused_addr_hi = |bus.addr[31:AW];

   assign req_ok     = bus.mem_en && is_aligned(bus.addr[1:0], bus.byte_acc);
   assign accept     = (state_q == ST_IDLE) && req_ok;
   assign access_now = (state_q == ST_BUSY) && (cnt_q == '0);
   assign ram_we     = access_now && !req_p0.load;

   assign bus.stall  = accept || (state_q == ST_BUSY);

   // Stage p0: request capture; upstream holds inputs, so one snapshot suffices.
   always_ff @(posedge clk) begin
      if (accept) begin
         req_p0.data     <= bus.store_data;
         req_p0.load     <= bus.load_instr;
         req_p0.byte_acc <= bus.byte_acc;
         req_p0.rd       <= bus.rd_in;
         req_addr_p0     <= bus.addr[AW-1:0];
      end
   end

   data_ram #(
      .MEM_BYTES (MEM_BYTES),
      .AW        (AW)
   ) u_data_ram (
      .clk      (clk),
      .we       (ram_we),
      .byte_sel (req_p0.byte_acc),
      .addr     (req_addr_p0),
      .wdata    (req_p0.data),
      .rdata    (ram_rdata)
   );

   // Stage p1: FSM and registered write-back outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         wb_data_p1 <= '0;
         wb_rd_p1   <= '0;
         wb_we_p1   <= 1'b0;
         fault_p1   <= 1'b0;
      end else begin
         fault_p1 <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (!bus.mem_en) begin
                  wb_data_p1 <= bus.alu_result;
                  wb_rd_p1   <= bus.rd_in;
                  wb_we_p1   <= bus.rf_we_in;
               end else if (req_ok) begin
                  state_q  <= ST_BUSY;
                  cnt_q    <= CNT_W'(WAIT_CYCLES - 1);
                  wb_we_p1 <= 1'b0;
               end else begin
                  fault_p1 <= 1'b1;
                  wb_we_p1 <= 1'b0;
               end
            end
            ST_BUSY: begin
               if (cnt_q == '0) begin
                  state_q  <= ST_DONE;
                  wb_we_p1 <= req_p0.load;
                  wb_rd_p1 <= req_p0.rd;
                  if (req_p0.load) begin
                     wb_data_p1 <= ram_rdata;
                  end
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            ST_DONE: begin
               state_q  <= ST_IDLE;
               wb_we_p1 <= 1'b0;
            end
            default: begin
               state_q  <= ST_IDLE;
               wb_we_p1 <= 1'b0;
            end
         endcase
      end
   end

   assign bus.wb_data     = wb_data_p1;
   assign bus.wb_rd       = wb_rd_p1;
   assign bus.wb_we       = wb_we_p1;
   assign bus.align_fault = fault_p1;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, reset-abort
// sequence, and randomized traffic against a byte-array reference model.
module tb_mem_stage;

   localparam int WAIT  = 2;
   localparam int BYTES = 256;

   logic clk;
   logic reset_n;
   int   n_cmp;
   int   n_fail;
   logic [7:0] mdl [BYTES];

   mem_stage_if bus();

   mem_stage #(.MEM_BYTES(BYTES), .WAIT_CYCLES(WAIT)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          is_mem;
      bit          ld;
      bit          by;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  rd;
      logic [31:0] exp;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a, input bit by);
      int b = int'(a % BYTES);
      if (by) return {24'd0, mdl[b]};
      return {mdl[b], mdl[(b + 1) % BYTES], mdl[(b + 2) % BYTES], mdl[(b + 3) % BYTES]};
   endfunction

   task automatic model_write(input logic [31:0] a, input bit by, input logic [31:0] d);
      int b = int'(a % BYTES);
      if (by) begin
         mdl[b] = d[7:0];
      end else begin
         for (int k = 0; k < 4; k++) mdl[(b + k) % BYTES] = d[31 - 8 * k -: 8];
      end
   endtask

   task automatic idle_inputs();
      bus.mem_en     = 1'b0;
      bus.load_instr = 1'b0;
      bus.byte_acc   = 1'b0;
      bus.addr       = 32'h0;
      bus.store_data = 32'h0;
      bus.alu_result = 32'h0BAD_F00D;
      bus.rf_we_in   = 1'b0;
      bus.rd_in      = 4'hE;
   endtask

   // Called just after a rising edge with the DUT idle; returns likewise.
   task automatic mem_op(input bit ld, input bit by, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] rd,
                         input logic [31:0] exp, input string tag);
      bit aligned = by || (a[1:0] == 2'b00);
      bus.mem_en     = 1'b1;
      bus.load_instr = ld;
      bus.byte_acc   = by;
      bus.addr       = a;
      bus.store_data = d;
      bus.rd_in      = rd;
      bus.rf_we_in   = 1'($urandom);
      bus.alu_result = $urandom;
      if (aligned) begin
         for (int c = 0; c <= WAIT; c++) begin
            @(negedge clk);
            chk({tag, "_stall"}, 32'(bus.stall), 32'd1);
            if (c > 0) begin
               chk({tag, "_busy_we"}, 32'(bus.wb_we), 32'd0);
               chk({tag, "_busy_fault"}, 32'(bus.align_fault), 32'd0);
            end
            @(posedge clk); #1;
         end
         @(negedge clk);
         chk({tag, "_done_stall"}, 32'(bus.stall), 32'd0);
         chk({tag, "_done_we"}, 32'(bus.wb_we), 32'(ld));
         chk({tag, "_done_fault"}, 32'(bus.align_fault), 32'd0);
         if (ld) begin
            chk({tag, "_data"}, bus.wb_data, exp);
            chk({tag, "_rd"}, 32'(bus.wb_rd), 32'(rd));
         end else begin
            model_write(a, by, d);
         end
         @(posedge clk); #1;
         idle_inputs();
      end else begin
         @(negedge clk);
         chk({tag, "_mis_stall"}, 32'(bus.stall), 32'd0);
         @(posedge clk); #1;
         idle_inputs();
         @(negedge clk);
         chk({tag, "_mis_fault"}, 32'(bus.align_fault), 32'd1);
         chk({tag, "_mis_we"}, 32'(bus.wb_we), 32'd0);
         @(posedge clk); #1;
         @(negedge clk);
         chk({tag, "_mis_fault_clr"}, 32'(bus.align_fault), 32'd0);
         @(posedge clk); #1;
      end
   endtask

   task automatic alu_op(input logic [31:0] res, input bit we, input logic [3:0] rd, input string tag);
      bus.mem_en     = 1'b0;
      bus.load_instr = 1'($urandom);
      bus.byte_acc   = 1'($urandom);
      bus.addr       = $urandom;
      bus.alu_result = res;
      bus.rf_we_in   = we;
      bus.rd_in      = rd;
      @(negedge clk);
      chk({tag, "_alu_stall"}, 32'(bus.stall), 32'd0);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      chk({tag, "_alu_data"}, bus.wb_data, res);
      chk({tag, "_alu_rd"}, 32'(bus.wb_rd), 32'(rd));
      chk({tag, "_alu_we"}, 32'(bus.wb_we), 32'(we));
      chk({tag, "_alu_fault"}, 32'(bus.align_fault), 32'd0);
      @(posedge clk); #1;
   endtask

   vec_t vt[11];

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      reset_n = 1'b0;
      idle_inputs();

      // Reset state, and combinational stall from IDLE while in reset.
      #3;
      chk("rst_wb_data", bus.wb_data, 32'd0);
      chk("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
      chk("rst_wb_we", 32'(bus.wb_we), 32'd0);
      chk("rst_fault", 32'(bus.align_fault), 32'd0);
      chk("rst_stall_idle", 32'(bus.stall), 32'd0);
      bus.mem_en = 1'b1;
      bus.load_instr = 1'b1;
      #1;
      chk("rst_stall_req", 32'(bus.stall), 32'd1);
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Fill storage so every later load has a defined expectation.
      for (int w = 0; w < BYTES / 4; w++) begin
         mem_op(1'b0, 1'b0, 32'(w * 4), $urandom, 4'h0, 32'h0, "pre");
      end

      vt[0]  = '{1, 0, 0, 32'h10,  32'hDEADBEEF, 4'd0, 32'h0};
      vt[1]  = '{1, 1, 0, 32'h10,  32'h0,        4'd5, 32'hDEADBEEF};
      vt[2]  = '{1, 1, 1, 32'h11,  32'h0,        4'd6, 32'h000000AD};
      vt[3]  = '{1, 1, 0, 32'h13,  32'h0,        4'd2, 32'h0};
      vt[4]  = '{1, 1, 0, 32'h10,  32'h0,        4'd5, 32'hDEADBEEF};
      vt[5]  = '{1, 0, 1, 32'h12,  32'h000000FF, 4'd0, 32'h0};
      vt[6]  = '{1, 1, 0, 32'h10,  32'h0,        4'd9, 32'hDEADFFEF};
      vt[7]  = '{0, 1, 0, 32'h0,   32'h5,        4'd3, 32'h0};
      vt[8]  = '{1, 0, 0, 32'h104, 32'hCAFEF00D, 4'd0, 32'h0};
      vt[9]  = '{1, 1, 0, 32'h4,   32'h0,        4'd1, 32'hCAFEF00D};
      vt[10] = '{0, 0, 0, 32'h0,   32'hFFFF0000, 4'd12, 32'h0};

      for (int i = 0; i < 11; i++) begin
         if (vt[i].is_mem)
            mem_op(vt[i].ld, vt[i].by, vt[i].addr, vt[i].data, vt[i].rd, vt[i].exp, $sformatf("vec%0d", i));
         else
            alu_op(vt[i].data, vt[i].ld, vt[i].rd, $sformatf("vec%0d", i));
      end

      // Reset while a store is in BUSY: access aborted, storage untouched.
      alu_op(32'hA5A5A5A5, 1'b1, 4'd7, "pre_rst");
      bus.mem_en     = 1'b1;
      bus.load_instr = 1'b0;
      bus.byte_acc   = 1'b0;
      bus.addr       = 32'h20;
      bus.store_data = 32'h12345678;
      bus.rd_in      = 4'd4;
      @(negedge clk);
      chk("abort_stall0", 32'(bus.stall), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_stall1", 32'(bus.stall), 32'd1);
      #1;
      reset_n = 1'b0;
      #1;
      chk("abort_wb_data", bus.wb_data, 32'd0);
      chk("abort_wb_rd", 32'(bus.wb_rd), 32'd0);
      chk("abort_wb_we", 32'(bus.wb_we), 32'd0);
      chk("abort_fault", 32'(bus.align_fault), 32'd0);
      chk("abort_stall_idle_req", 32'(bus.stall), 32'd1);
      idle_inputs();
      #1;
      chk("abort_stall_idle", 32'(bus.stall), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      mem_op(1'b1, 1'b0, 32'h20, 32'h0, 4'd8, model_read(32'h20, 1'b0), "abort_keep");
      mem_op(1'b0, 1'b0, 32'h20, 32'h12345678, 4'd0, 32'h0, "post_st");
      mem_op(1'b1, 1'b0, 32'h20, 32'h0, 4'd8, 32'h12345678, "post_ld");

      // Randomized traffic against the byte-array model.
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 9) < 2) begin
            alu_op($urandom, 1'($urandom), 4'($urandom), "rnd");
         end else begin
            bit          ld = 1'($urandom);
            bit          by = 1'($urandom);
            logic [31:0] a  = $urandom;
            if (!by && $urandom_range(0, 4) != 0) a[1:0] = 2'b00;
            mem_op(ld, by, a, $urandom, 4'($urandom), model_read(a, by), "rnd");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
